// File: rtl/mm_pkg.sv
// Shared definitions for the modular-multiplication datapath: operand width
// and the reducer's state encoding.
package mm_pkg;
  localparam int N = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cond_sub.sv
// One restoring-division step: subtract the modulus when the partial
// remainder has reached it. The caller guarantees t < 2*M, so r < M.
module cond_sub #(
  parameter int N = 256
) (
  input  logic [N:0]   t,
  input  logic [N-1:0] M,
  output logic [N-1:0] r
);
  assign r = (t >= {1'b0, M}) ? N'(t - {1'b0, M}) : t[N-1:0];
endmodule

// File: rtl/mod_reduce.sv
// Bit-serial reduction of a 2N-bit product modulo an N-bit modulus,
// one quotient bit per cycle, with valid/ready handshakes on both sides.
module mod_reduce #(
  parameter int N = mm_pkg::N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   M,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   R,
  output logic           err
);
  import mm_pkg::state_t;
  import mm_pkg::IDLE;
  import mm_pkg::RUN;
  import mm_pkg::DONE;

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_BIT = CW'(2 * N - 1);

  state_t         state_q, state_d;
  logic [2*N-1:0] shift_q, shift_d;
  logic [N-1:0]   mod_q, mod_d;
  logic [N-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [N:0]     t;
  logic [N-1:0]   sub_r;

  assign t = {r_q, shift_q[2*N-1]};

  cond_sub #(.N(N)) u_cond_sub (
    .t (t),
    .M (mod_q),
    .r (sub_r)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mod_d   = mod_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = P;
          mod_d   = M;
          r_d     = '0;
          cnt_d   = LAST_BIT;
          // A zero modulus has no meaningful remainder; report it at once.
          if (M == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d     = sub_r;
        shift_d = {shift_q[2*N-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      mod_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mod_q   <= mod_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign R         = r_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mod_reduce.sv
// Scoreboard bench for mod_reduce: stimulus pushes expected results, a
// negedge monitor checks latency, result, and the post-consume handshake.
module tb_mod_reduce;
  localparam int N = mm_pkg::N;

  typedef struct {
    logic [N-1:0] r;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] P = '0;
  logic [N-1:0]   M = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [N-1:0]   R;
  logic           err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   prev_ov = 1'b0;
  bit   chk_drop = 1'b0;

  mod_reduce #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .M         (M),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .err       (err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] rnd_n();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input logic [2*N-1:0] p, input logic [N-1:0] m,
                       input logic [N-1:0] er, input logic ee, input bit scramble);
    int w;
    exp_t x;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 3000) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 256'(in_ready), 256'(1));
      return;
    end
    in_valid = 1'b1;
    P = p;
    M = m;
    @(posedge clock);
    #1;
    x.r = er;
    x.e = ee;
    x.lat = (m == '0) ? 0 : 2 * N;
    x.acc = cyc;
    sb.push_back(x);
    in_valid = 1'b0;
    $display("issue P=%0h M=%0h expect R=%0h err=%0b", p, m, er, ee);
    if (scramble) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        P = {rnd_n(), rnd_n()};
        M = rnd_n();
        in_valid = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
    end
  endtask

  // Monitor: latency on out_valid rise, value on handshake, ready/valid after consume.
  always @(negedge clock) begin
    if (reset) begin
      prev_ov  = 1'b0;
      chk_drop = 1'b0;
    end else begin
      if (chk_drop) begin
        chk("drop_out_valid", 256'(out_valid), 256'(0));
        chk("rise_in_ready", 256'(in_ready), 256'(1));
        chk_drop = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 256'(out_valid), 256'(0));
        else chk("latency", 256'(cyc - sb[0].acc), 256'(sb[0].lat));
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        chk("R", R, sb[0].r);
        chk("err", 256'(err), 256'(sb[0].e));
        $display("result R=%0h err=%0b", R, err);
        void'(sb.pop_front());
        chk_drop = 1'b1;
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [2*N-1:0] p;
    logic [N-1:0]   m, x, y, er;
    logic [2*N-1:0] prod, m_w;
    int w;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_in_ready", 256'(in_ready), 256'(1));
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_R", R, '0);
    chk("reset_err", 256'(err), 256'(0));

    issue('0, 256'd7, '0, 1'b0, 1'b1);
    issue(512'd100, 256'd7, 256'd2, 1'b0, 1'b1);
    p = '1; m = '1;
    issue(p, m, '0, 1'b0, 1'b1);
    p = '0; p[N] = 1'b1; p[2:0] = 3'd5;
    issue(p, m, 256'd6, 1'b0, 1'b1);
    issue(512'd12345, 256'd1, '0, 1'b0, 1'b1);
    issue({rnd_n(), rnd_n()}, '0, '0, 1'b1, 1'b0);

    // Hold the result in DONE with out_ready low and in_valid pulsing.
    @(negedge clock);
    while (in_ready !== 1'b1) @(negedge clock);
    out_ready = 1'b0;
    issue(512'd100, 256'd7, 256'd2, 1'b0, 1'b0);
    w = 0;
    @(negedge clock);
    while (!out_valid && w < 2000) begin
      @(negedge clock);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", 256'(out_valid), 256'(1));
      chk("hold_in_ready", 256'(in_ready), 256'(0));
      chk("hold_R", R, 256'd2);
      chk("hold_err", 256'(err), 256'(0));
      in_valid = ~in_valid;
      P = {rnd_n(), rnd_n()};
      M = '0;
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset landing on the 100th RUN edge discards the operation.
    issue(512'd100, 256'd7, 256'd2, 1'b0, 1'b0);
    repeat (99) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.delete();
    chk("midrun_reset_in_ready", 256'(in_ready), 256'(1));
    chk("midrun_reset_out_valid", 256'(out_valid), 256'(0));
    chk("midrun_reset_R", R, '0);
    reset = 1'b0;
    issue(512'd100, 256'd7, 256'd2, 1'b0, 1'b0);

    // Product of two residues, with inputs scrambled during RUN.
    for (int k = 0; k < 3; k++) begin
      m = rnd_n() | 256'd1;
      x = rnd_n() % m;
      y = rnd_n() % m;
      prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
      m_w = {{N{1'b0}}, m};
      er = N'(prod % m_w);
      issue(prod, m, er, 1'b0, 1'b1);
    end

    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clock);
      w++;
    end
    chk("drain_pending", 256'(sb.size()), 256'(0));
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
